// File: rtl/bronco_matvec_ctrl_pkg.sv
// Shared widths, opcodes, FSM state and command types for the bronco mat-vec controller.
package bronco_params;

  localparam int unsigned DefDataWidth = 8;
  localparam int unsigned DefAccWidth  = 16;
  localparam int unsigned DefAddrWidth = 8;
  localparam int unsigned DefMatDim    = 4;
  localparam int unsigned IDX_WIDTH    = $clog2(DefMatDim);

  typedef enum logic [1:0] {
    OpSetWBase = 2'd0,
    OpSetXBase = 2'd1,
    OpRun      = 2'd2,
    OpRsvd     = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    StIdle,
    StLoadX,
    StMac,
    StEmit
  } ctrl_state_e;

  typedef struct packed {
    op_e                     op;
    logic [DefAddrWidth-1:0] arg;
  } cmd_t;

endpackage

// File: rtl/bronco_matvec_ctrl_mac.sv
// Signed multiply-accumulate with synchronous clear; the sum wraps at ACC_WIDTH bits.
module bronco_mac #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ACC_WIDTH  = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         clear_i,
  input  logic                         en_i,
  input  logic signed [DATA_WIDTH-1:0] w_i,
  input  logic signed [DATA_WIDTH-1:0] x_i,
  output logic signed [ACC_WIDTH-1:0]  acc_o
);

  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]    acc_d, acc_q;

  always_comb begin
    prod  = (2*DATA_WIDTH)'(w_i) * (2*DATA_WIDTH)'(x_i);
    acc_d = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + ACC_WIDTH'(prod);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/bronco_matvec_ctrl.sv
// Command-driven y = W*x sequencer: loads x, streams W rows through one MAC, emits y rows.
module bronco_matvec_ctrl
  import bronco_params::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned ACC_WIDTH  = DefAccWidth,
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned MAT_DIM    = DefMatDim
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       cmd_valid_i,
  output logic                       cmd_ready_o,
  input  logic [1:0]                 cmd_op_i,
  input  logic [ADDR_WIDTH-1:0]      cmd_arg_i,
  output logic                       mem_req_o,
  output logic [ADDR_WIDTH-1:0]      mem_addr_o,
  input  logic [DATA_WIDTH-1:0]      mem_rdata_i,
  output logic                       y_valid_o,
  input  logic                       y_ready_i,
  output logic [ACC_WIDTH-1:0]       y_data_o,
  output logic [$clog2(MAT_DIM)-1:0] y_idx_o,
  output logic                       y_last_o,
  output logic                       busy_o,
  output logic                       err_op_o
);

  localparam int unsigned IdxW = $clog2(MAT_DIM);
  localparam int unsigned ColW = IdxW + 1;

  ctrl_state_e            state_d, state_q;
  logic [ADDR_WIDTH-1:0]  w_base_d, w_base_q, x_base_d, x_base_q;
  logic [IdxW-1:0]        row_d, row_q, rcol_q;
  logic [ColW-1:0]        col_d, col_q;
  logic                   err_d, err_q, rvalid_q, rx_q;
  logic [DATA_WIDTH-1:0]  x_q [MAT_DIM];
  logic signed [ACC_WIDTH-1:0] acc;
  cmd_t                   cmd;
  logic                   cmd_hs, issue, row_last, col_last, mac_clear, mac_en;
  logic [ADDR_WIDTH-1:0]  row_off, col_off;

  assign cmd       = '{op: op_e'(cmd_op_i), arg: DefAddrWidth'(cmd_arg_i)};
  assign cmd_hs    = cmd_valid_i && (state_q == StIdle);
  assign row_last  = (row_q == IdxW'(MAT_DIM - 1));
  assign col_last  = (col_q == ColW'(MAT_DIM - 1));
  assign issue     = ((state_q == StLoadX) || (state_q == StMac)) && (col_q < ColW'(MAT_DIM));
  // Row ends once the read data of its last column has come back.
  assign mac_en    = rvalid_q && !rx_q;
  assign mac_clear = (state_q == StMac) && (col_q == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (cmd_hs && (cmd.op == OpRun)) state_d = StLoadX;
      StLoadX: if (col_last) state_d = StMac;
      StMac:   if (mac_en && (rcol_q == IdxW'(MAT_DIM - 1))) state_d = StEmit;
      StEmit:  if (y_ready_i) state_d = row_last ? StIdle : StMac;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    row_off     = ADDR_WIDTH'(row_q) * ADDR_WIDTH'(MAT_DIM);
    col_off     = ADDR_WIDTH'(col_q);
    cmd_ready_o = (state_q == StIdle);
    busy_o      = (state_q != StIdle);
    y_valid_o   = (state_q == StEmit);
    y_last_o    = y_valid_o && row_last;
    y_idx_o     = row_q;
    y_data_o    = acc;
    err_op_o    = err_q;
    mem_req_o   = issue;
    mem_addr_o  = '0;
    if (issue) begin
      mem_addr_o = (state_q == StLoadX) ? (x_base_q + col_off) : (w_base_q + row_off + col_off);
    end
  end

  always_comb begin
    w_base_d = w_base_q;
    x_base_d = x_base_q;
    row_d    = row_q;
    col_d    = col_q;
    err_d    = 1'b0;
    if (cmd_hs) begin
      unique case (cmd.op)
        OpSetWBase: w_base_d = ADDR_WIDTH'(cmd.arg);
        OpSetXBase: x_base_d = ADDR_WIDTH'(cmd.arg);
        OpRsvd:     err_d    = 1'b1;
        default:    ;
      endcase
    end
    unique case (state_q)
      StIdle:  begin
        row_d = '0;
        col_d = '0;
      end
      StLoadX: col_d = col_last ? '0 : col_q + 1'b1;
      StMac:   if (issue) col_d = col_q + 1'b1;
      StEmit:  if (y_ready_i) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_base_q <= '0;
      x_base_q <= '0;
      row_q    <= '0;
      col_q    <= '0;
      err_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rx_q     <= 1'b0;
      rcol_q   <= '0;
      for (int j = 0; j < MAT_DIM; j++) x_q[j] <= '0;
    end else begin
      w_base_q <= w_base_d;
      x_base_q <= x_base_d;
      row_q    <= row_d;
      col_q    <= col_d;
      err_q    <= err_d;
      rvalid_q <= issue;
      rx_q     <= (state_q == StLoadX);
      rcol_q   <= col_q[IdxW-1:0];
      if (rvalid_q && rx_q) x_q[rcol_q] <= mem_rdata_i;
    end
  end

  bronco_mac #(
    .DATA_WIDTH(DATA_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_mac (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clear_i(mac_clear),
    .en_i   (mac_en),
    .w_i    (mem_rdata_i),
    .x_i    (x_q[rcol_q]),
    .acc_o  (acc)
  );

endmodule
